and_mux_gate: RTL and testbench



---
 rtl/gates_pkg.sv | 17 +
 rtl/mux2.sv | 19 +
 rtl/and_mux_gate.sv | 54 +++++
 tb/tb_and_mux_gate.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/gates_pkg.sv
// ============================================================================
// Module : gates_pkg
// Brief  : Shared constants and types for the mux-derived basic-gates library.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gates_pkg;

  localparam int GATES_DEFAULT_WIDTH = 1;

  // Operand vector at the library default width, shared by sibling mux-based gates.
  typedef logic [GATES_DEFAULT_WIDTH-1:0] gates_vec_t;

endpackage : gates_pkg

`default_nettype wire

// File: rtl/mux2.sv
// ============================================================================
// Module : mux2
// Brief  : 1-bit 2:1 multiplexer primitive; y = sel ? d1 : d0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux2 (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule : mux2

`default_nettype wire

// File: rtl/and_mux_gate.sv
// ============================================================================
// Module : and_mux_gate
// Brief  : Bit-sliced AND built only from 2:1 muxes, with combinational Z and
//          registered Z_q. Macro AND_MUX_GATE_REG_EN enables the Z_q flop;
//          without it Z_q is a combinational alias of Z.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module and_mux_gate
  import gates_pkg::*;
#(
  parameter int WIDTH = GATES_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] Z_q
);

  // A selects: when low the grounded d0 leg wins, when high B passes through.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_slice
      mux2 u_mux2 (
        .sel (A[i]),
        .d0  (1'b0),
        .d1  (B[i]),
        .y   (Z[i])
      );
    end
  endgenerate

`ifdef AND_MUX_GATE_REG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Z_q <= '0;
    end else begin
      Z_q <= Z;
    end
  end
`else
  assign Z_q = Z;

  // clk and rst stay on the port list so both builds share one footprint.
  logic unused_ports;
  assign unused_ports = clk ^ rst;
`endif

endmodule : and_mux_gate

`default_nettype wire

// File: tb/tb_and_mux_gate.sv
// ============================================================================
// Module : tb_and_mux_gate
// Brief  : Directed self-checking bench for and_mux_gate (WIDTH=1 and WIDTH=4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_and_mux_gate;

`ifdef AND_MUX_GATE_REG_EN
  localparam bit REG_EN = 1'b1;
`else
  localparam bit REG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic [0:0] z1, zq1;
  logic [3:0] a4 = '0, b4 = '0;
  logic [3:0] z4, zq4;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  and_mux_gate #(.WIDTH(1)) dut1 (
    .clk (clk), .rst (rst), .A (a1), .B (b1), .Z (z1), .Z_q (zq1)
  );

  and_mux_gate #(.WIDTH(4)) dut4 (
    .clk (clk), .rst (rst), .A (a4), .B (b4), .Z (z4), .Z_q (zq4)
  );

  task automatic test_reset;
    rst = 1'b1; a1 = 1'b0; b1 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    #1;
    total++;
    if (zq1 !== 1'b0) $display("FAIL reset_zq1: got %b want 0", zq1);
    else passed++;
    total++;
    if (zq4 !== 4'h0) $display("FAIL reset_zq4: got %b want 0000", zq4);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_truth_table;
    logic [1:0] vec [4];
    logic       exp [4];
    vec = '{2'b00, 2'b10, 2'b01, 2'b11};  // {A,B}
    exp = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      a1 = vec[k][1];
      b1 = vec[k][0];
      #1;
      total++;
      if (z1 !== exp[k]) $display("FAIL truth_%0d: A=%b B=%b Z got %b want %b", k, a1, b1, z1, exp[k]);
      else passed++;
      #1;
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1;
    @(posedge clk);
    #2;
    total++;
    if (zq1 !== 1'b1) $display("FAIL pre_reset_zq: got %b want 1", zq1);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if (zq1 !== (REG_EN ? 1'b0 : 1'b1)) $display("FAIL async_clear_zq: got %b want %b", zq1, ~REG_EN);
    else passed++;
    total++;
    if (z1 !== 1'b1) $display("FAIL reset_z_tracks: got %b want 1", z1);
    else passed++;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if (zq1 !== (REG_EN ? 1'b0 : 1'b1) || z1 !== 1'b1)
        $display("FAIL reset_hold_%0d: Z=%b Z_q=%b want Z=1 Z_q=%b", k, z1, zq1, ~REG_EN);
      else passed++;
    end
  endtask

  task automatic test_release;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (zq1 !== (REG_EN ? 1'b0 : 1'b1)) $display("FAIL release_before_edge: got %b want %b", zq1, ~REG_EN);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (zq1 !== 1'b1) $display("FAIL release_first_edge: got %b want 1", zq1);
    else passed++;
  endtask

  task automatic test_width4;
    @(negedge clk);
    a4 = 4'b1100; b4 = 4'b1010;
    #1;
    total++;
    if (z4 !== 4'b1000) $display("FAIL w4_z: got %b want 1000", z4);
    else passed++;
    total++;
    if (zq4 !== (REG_EN ? 4'b0000 : 4'b1000)) $display("FAIL w4_zq_before_edge: got %b want %b", zq4, REG_EN ? 4'b0000 : 4'b1000);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (zq4 !== 4'b1000) $display("FAIL w4_zq_after_edge: got %b want 1000", zq4);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [3:0] va [3];
    logic [3:0] vb [3];
    logic [3:0] ve [3];
    va = '{4'b1111, 4'b0110, 4'b1010};
    vb = '{4'b0101, 4'b1100, 4'b1111};
    ve = '{4'b0101, 4'b0100, 4'b1010};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a4 = va[k]; b4 = vb[k];
      @(posedge clk);
      #1;
      total++;
      if (zq4 !== ve[k] || z4 !== ve[k]) $display("FAIL b2b_%0d: Z=%b Z_q=%b want %b", k, z4, zq4, ve[k]);
      else passed++;
    end
  endtask

  task automatic test_x_select;
    @(negedge clk);
    a4 = 4'bxx11; b4 = 4'b0011;
    #1;
    total++;
    if (z4 !== 4'b0011) $display("FAIL x_sel_b0: got %b want 0011", z4);
    else passed++;
  endtask

  task automatic test_glitch;
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1;
    @(posedge clk);
    #1;
    a1 = 1'b1;
    #1;
    total++;
    if (z1 !== 1'b1 || zq1 !== (REG_EN ? 1'b0 : 1'b1))
      $display("FAIL glitch_high: Z=%b Z_q=%b want Z=1 Z_q=%b", z1, zq1, ~REG_EN);
    else passed++;
    #1;
    a1 = 1'b0;
    #1;
    total++;
    if (z1 !== 1'b0) $display("FAIL glitch_low: got %b want 0", z1);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (zq1 !== 1'b0) $display("FAIL glitch_zq: got %b want 0", zq1);
    else passed++;
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    a4 = 4'b0111; b4 = 4'b1011;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (z4 !== 4'b0011 || zq4 !== (REG_EN ? 4'b0000 : 4'b0011))
      $display("FAIL mid_reset: Z=%b Z_q=%b want Z=0011 Z_q=%b", z4, zq4, REG_EN ? 4'b0000 : 4'b0011);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_async_reset();
    test_release();
    test_width4();
    test_back_to_back();
    test_x_select();
    test_glitch();
    test_reset_mid_op();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_and_mux_gate

`default_nettype wire
